// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg : PID codes, parser state encoding and PID classes for the USB parser
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usb_pkg;

   localparam int MAX_DATA_BYTES = 66;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ_PID = 3'd1,
      ST_TOKEN1   = 3'd2,
      ST_TOKEN2   = 3'd3,
      ST_DATA     = 3'd4,
      ST_HSHAKE   = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERR      = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      PC_TOKEN   = 2'd0,
      PC_DATA    = 2'd1,
      PC_HSHAKE  = 2'd2,
      PC_ILLEGAL = 2'd3
   } pid_class_t;

endpackage

`default_nettype wire

// File: rtl/usb_packet_parser_pid_checker.sv
// ---------------------------------------------------------------------------
// pid_checker : combinational PID byte check (nibble complement) and classifier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pid_checker
   import usb_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic       o_valid,
   output pid_class_t o_class
);

   always_comb begin
      o_valid = (i_byte[7:4] == ~i_byte[3:0]);
      case (i_byte[3:0])
         PID_OUT, PID_IN, PID_SETUP: o_class = PC_TOKEN;
         PID_DATA0, PID_DATA1:       o_class = PC_DATA;
         PID_ACK, PID_NAK, PID_STALL: o_class = PC_HSHAKE;
         default:                    o_class = PC_ILLEGAL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/usb_packet_parser.sv
// ---------------------------------------------------------------------------
// usb_packet_parser : pops receiver FIFO bytes and decodes token/data/handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_packet_parser
   import usb_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rcving,
   input  logic       empty,
   input  logic [7:0] r_data,
   input  logic       r_error,
   output logic       r_enable,
   output logic [3:0] pid,
   output logic [6:0] addr,
   output logic [3:0] endp,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic [6:0] byte_cnt,
   output logic       pkt_done,
   output logic       pkt_error
);

   state_t     r_state;
   state_t     w_next;
   logic       w_pid_valid;
   pid_class_t w_pid_class;
   logic       w_rx_over;

   assign w_rx_over = !rcving && empty;

   pid_checker u_pid_checker (
      .i_byte  (r_data),
      .o_valid (w_pid_valid),
      .o_class (w_pid_class)
   );

   always_comb begin
      w_next   = r_state;
      r_enable = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rcving || !empty) w_next = ST_READ_PID;
         end
         ST_READ_PID: begin
            if (!empty) begin
               r_enable = 1'b1;
               if (!w_pid_valid) begin
                  w_next = ST_ERR;
               end else begin
                  case (w_pid_class)
                     PC_TOKEN:  w_next = ST_TOKEN1;
                     PC_DATA:   w_next = ST_DATA;
                     PC_HSHAKE: w_next = ST_HSHAKE;
                     default:   w_next = ST_ERR;
                  endcase
               end
            end else if (w_rx_over) begin
               // receiver gave up before any PID byte arrived
               w_next = ST_ERR;
            end
         end
         ST_TOKEN1: begin
            if (!empty) begin
               r_enable = 1'b1;
               w_next   = ST_TOKEN2;
            end else if (w_rx_over) begin
               w_next = ST_ERR;
            end
         end
         ST_TOKEN2: begin
            if (!empty) begin
               r_enable = 1'b1;
               w_next   = ST_DONE;
            end else if (w_rx_over) begin
               w_next = ST_ERR;
            end
         end
         ST_DATA: begin
            if (!empty) begin
               r_enable = 1'b1;
               if (byte_cnt == 7'(MAX_DATA_BYTES)) w_next = ST_ERR;
            end else if (w_rx_over) begin
               w_next = (byte_cnt >= 7'd2) ? ST_DONE : ST_ERR;
            end
         end
         ST_HSHAKE: begin
            if (!empty)       w_next = ST_ERR;
            else if (!rcving) w_next = ST_DONE;
         end
         ST_DONE: begin
            if (!rcving) w_next = ST_IDLE;
         end
         ST_ERR: begin
            r_enable = !empty;
            if (w_rx_over) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase

      // a receiver error overrides everything; ERR keeps draining meanwhile
      if (r_error && (r_state != ST_IDLE)) begin
         w_next = ST_ERR;
         if (r_state != ST_ERR) r_enable = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= ST_IDLE;
         pid        <= 4'd0;
         addr       <= 7'd0;
         endp       <= 4'd0;
         data_out   <= 8'd0;
         data_valid <= 1'b0;
         byte_cnt   <= 7'd0;
         pkt_done   <= 1'b0;
         pkt_error  <= 1'b0;
      end else begin
         r_state    <= w_next;
         data_valid <= 1'b0;
         pkt_done   <= (w_next == ST_DONE) && (r_state != ST_DONE);
         pkt_error  <= (w_next == ST_ERR) && (r_state != ST_ERR);
         if ((r_state == ST_IDLE) && (w_next == ST_READ_PID)) byte_cnt <= 7'd0;
         if (r_enable) begin
            case (r_state)
               ST_READ_PID: begin
                  if (w_pid_valid && (w_pid_class != PC_ILLEGAL)) pid <= r_data[3:0];
               end
               ST_TOKEN1: begin
                  addr    <= r_data[6:0];
                  endp[0] <= r_data[7];
               end
               ST_TOKEN2: begin
                  endp[3:1] <= r_data[2:0];
               end
               ST_DATA: begin
                  // the overflowing byte is popped but never forwarded
                  if (w_next == ST_DATA) begin
                     data_out   <= r_data;
                     data_valid <= 1'b1;
                     byte_cnt   <= byte_cnt + 7'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_usb_packet_parser.sv
// ---------------------------------------------------------------------------
// tb_usb_packet_parser : randomized and directed checks against a packet model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_packet_parser;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       rcving;
   logic       empty;
   logic [7:0] r_data;
   logic       r_error;
   logic       r_enable;
   logic [3:0] pid;
   logic [6:0] addr;
   logic [3:0] endp;
   logic [7:0] data_out;
   logic       data_valid;
   logic [6:0] byte_cnt;
   logic       pkt_done;
   logic       pkt_error;

   usb_packet_parser dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .rcving     (rcving),
      .empty      (empty),
      .r_data     (r_data),
      .r_error    (r_error),
      .r_enable   (r_enable),
      .pid        (pid),
      .addr       (addr),
      .endp       (endp),
      .data_out   (data_out),
      .data_valid (data_valid),
      .byte_cnt   (byte_cnt),
      .pkt_done   (pkt_done),
      .pkt_error  (pkt_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q[$];
   logic [7:0] obs_data[$];
   int         obs_done, obs_err, viol;
   bit         to_flag;

   logic [7:0] exp_data[$];
   int         exp_done, exp_err;
   logic [3:0] exp_pid  = 4'd0;
   logic [6:0] exp_addr = 7'd0;
   logic [3:0] exp_endp = 4'd0;
   logic [6:0] exp_cnt;

   task automatic update_fifo();
      empty  = (q.size() == 0);
      r_data = (q.size() > 0) ? q[0] : 8'($urandom);
   endtask

   task automatic tick();
      logic en;
      update_fifo();
      #1;
      en = r_enable;
      if (en && empty) viol++;
      @(posedge clk);
      #1;
      if (en && q.size() > 0) void'(q.pop_front());
      if (data_valid) obs_data.push_back(data_out);
      if (pkt_done)   obs_done++;
      if (pkt_error)  obs_err++;
      update_fifo();
   endtask

   task automatic clear_obs();
      obs_data.delete();
      obs_done = 0;
      obs_err  = 0;
      viol     = 0;
   endtask

   task automatic settle();
      to_flag = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if ((obs_done + obs_err) > 0 && q.size() == 0 && k > 4) begin
            to_flag = 1'b0;
            break;
         end
      end
   endtask

   task automatic send_pkt(input logic [7:0] b[$]);
      clear_obs();
      rcving = 1'b1;
      tick();
      foreach (b[i]) begin
         repeat ($urandom_range(0, 2)) tick();
         q.push_back(b[i]);
         tick();
      end
      repeat ($urandom_range(0, 3)) tick();
      rcving = 1'b0;
      settle();
   endtask

   // Packet-level expectation from the protocol rules
   task automatic model_pkt(input logic [7:0] b[$]);
      logic [7:0] p, t;
      int n;
      exp_data.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_cnt  = 7'd0;
      p = b[0];
      if (p[7:4] != ~p[3:0]) begin
         exp_err = 1;
         return;
      end
      case (p[3:0])
         4'h1, 4'h9, 4'hD: begin
            exp_pid = p[3:0];
            if (b.size() >= 2) begin
               t = b[1];
               exp_addr    = t[6:0];
               exp_endp[0] = t[7];
            end
            if (b.size() >= 3) begin
               t = b[2];
               exp_endp[3:1] = t[2:0];
            end
            if (b.size() == 3) exp_done = 1;
            else               exp_err  = 1;
         end
         4'h3, 4'hB: begin
            exp_pid = p[3:0];
            n = b.size() - 1;
            for (int i = 1; i <= n && i <= 66; i++) exp_data.push_back(b[i]);
            exp_cnt = 7'(exp_data.size());
            if (n > 66 || n < 2) exp_err  = 1;
            else                 exp_done = 1;
         end
         4'h2, 4'hA, 4'hE: begin
            exp_pid = p[3:0];
            if (b.size() == 1) exp_done = 1;
            else               exp_err  = 1;
         end
         default: exp_err = 1;
      endcase
   endtask

   task automatic test_reset();
      n_rst   = 1'b0;
      rcving  = 1'b0;
      r_error = 1'b0;
      q.delete();
      update_fifo();
      #3;
      n_checks++;
      if ({r_enable, pid, addr, endp, data_out, data_valid, byte_cnt, pkt_done, pkt_error} !== 35'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {r_enable, pid, addr, endp, data_out, data_valid, byte_cnt, pkt_done, pkt_error});
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      clear_obs();
      repeat (3) tick();
      n_checks++;
      if (obs_done + obs_err + obs_data.size() != 0 || r_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: done=%0d err=%0d data=%0d r_enable=%b expected all 0",
                  obs_done, obs_err, obs_data.size(), r_enable);
      end
   endtask

   task automatic test_random();
      logic [7:0] pk[$];
      logic [3:0] nib;
      int kind, n;
      bit ok;
      int lens[8] = '{0, 1, 2, 3, 5, 8, 66, 67};
      for (int it = 0; it < 24; it++) begin
         pk.delete();
         kind = (it < 8) ? 1 : $urandom_range(0, 3);
         case (kind)
            0: begin
               case ($urandom_range(0, 2))
                  0: nib = 4'h1;
                  1: nib = 4'h9;
                  default: nib = 4'hD;
               endcase
               pk.push_back({~nib, nib});
               n = ($urandom_range(0, 3) == 0) ? 1 : 2;
               repeat (n) pk.push_back(8'($urandom));
            end
            1: begin
               nib = $urandom_range(0, 1) ? 4'h3 : 4'hB;
               pk.push_back({~nib, nib});
               n = (it < 8) ? lens[it] : lens[$urandom_range(0, 7)];
               repeat (n) pk.push_back(8'($urandom));
            end
            2: begin
               case ($urandom_range(0, 2))
                  0: nib = 4'h2;
                  1: nib = 4'hA;
                  default: nib = 4'hE;
               endcase
               pk.push_back({~nib, nib});
               if ($urandom_range(0, 2) == 0) pk.push_back(8'($urandom));
            end
            default: begin
               nib = 4'($urandom);
               pk.push_back($urandom_range(0, 1) ? {~nib, nib} : 8'($urandom));
               repeat ($urandom_range(0, 3)) pk.push_back(8'($urandom));
            end
         endcase
         model_pkt(pk);
         send_pkt(pk);
         n_checks++;
         if (to_flag) begin
            n_errors++;
            $display("FAIL rnd_timeout[%0d]: no completion within budget", it);
         end
         n_checks++;
         if (obs_done !== exp_done || obs_err !== exp_err) begin
            n_errors++;
            $display("FAIL rnd_status[%0d]: done=%0d err=%0d expected done=%0d err=%0d",
                     it, obs_done, obs_err, exp_done, exp_err);
         end
         ok = (obs_data.size() == exp_data.size());
         for (int i = 0; ok && i < exp_data.size(); i++) ok = (obs_data[i] === exp_data[i]);
         n_checks++;
         if (!ok) begin
            n_errors++;
            $display("FAIL rnd_data[%0d]: got %0d bytes expected %0d bytes (or content differs)",
                     it, obs_data.size(), exp_data.size());
         end
         n_checks++;
         if (pid !== exp_pid || addr !== exp_addr || endp !== exp_endp) begin
            n_errors++;
            $display("FAIL rnd_fields[%0d]: pid=%h addr=%h endp=%h expected pid=%h addr=%h endp=%h",
                     it, pid, addr, endp, exp_pid, exp_addr, exp_endp);
         end
         n_checks++;
         if (byte_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL rnd_byte_cnt[%0d]: got %0d expected %0d", it, byte_cnt, exp_cnt);
         end
         n_checks++;
         if (viol != 0 || q.size() != 0) begin
            n_errors++;
            $display("FAIL rnd_fifo[%0d]: pops_on_empty=%0d left=%0d expected 0 and 0",
                     it, viol, q.size());
         end
      end
   endtask

   task automatic test_in_token();
      logic [7:0] pk[$];
      pk = '{8'h69, 8'h85, 8'h40};
      send_pkt(pk);
      n_checks++;
      if (pid !== 4'b1001 || addr !== 7'h05 || endp !== 4'h1) begin
         n_errors++;
         $display("FAIL in_token_fields: pid=%h addr=%h endp=%h expected 9 05 1", pid, addr, endp);
      end
      n_checks++;
      if (obs_done !== 1 || obs_err !== 0 || obs_data.size() != 0) begin
         n_errors++;
         $display("FAIL in_token_status: done=%0d err=%0d data=%0d expected 1 0 0",
                  obs_done, obs_err, obs_data.size());
      end
   endtask

   task automatic test_data0();
      logic [7:0] pk[$];
      pk = '{8'hC3, 8'h11, 8'h22, 8'hAA, 8'hBB};
      send_pkt(pk);
      n_checks++;
      if (obs_data.size() != 4 ||
          obs_data[0] !== 8'h11 || obs_data[1] !== 8'h22 ||
          obs_data[2] !== 8'hAA || obs_data[3] !== 8'hBB) begin
         n_errors++;
         $display("FAIL data0_bytes: got %0d strobes expected 11 22 AA BB", obs_data.size());
      end
      n_checks++;
      if (byte_cnt !== 7'd4 || obs_done !== 1 || obs_err !== 0 || pid !== 4'h3) begin
         n_errors++;
         $display("FAIL data0_status: byte_cnt=%0d done=%0d err=%0d pid=%h expected 4 1 0 3",
                  byte_cnt, obs_done, obs_err, pid);
      end
   endtask

   task automatic test_bad_pid();
      logic [7:0] pk[$];
      pk = '{8'h55, 8'h12, 8'h34};
      send_pkt(pk);
      n_checks++;
      if (obs_err !== 1 || obs_done !== 0 || obs_data.size() != 0 || q.size() != 0 || to_flag) begin
         n_errors++;
         $display("FAIL bad_pid: err=%0d done=%0d data=%0d left=%0d expected 1 0 0 0",
                  obs_err, obs_done, obs_data.size(), q.size());
      end
   endtask

   task automatic test_ack_extra();
      logic [7:0] pk[$];
      pk = '{8'hD2, 8'h00};
      send_pkt(pk);
      n_checks++;
      if (obs_err !== 1 || obs_done !== 0 || pid !== 4'h2 || q.size() != 0) begin
         n_errors++;
         $display("FAIL ack_extra: err=%0d done=%0d pid=%h left=%0d expected 1 0 2 0",
                  obs_err, obs_done, pid, q.size());
      end
   endtask

   task automatic test_rerror_mid_data();
      logic [7:0] d[3];
      bit ok;
      foreach (d[i]) d[i] = 8'($urandom);
      clear_obs();
      rcving = 1'b1;
      tick();
      q.push_back(8'hC3);
      tick();
      foreach (d[i]) begin
         q.push_back(d[i]);
         tick();
      end
      repeat (2) tick();
      r_error = 1'b1;
      tick();
      r_error = 1'b0;
      n_checks++;
      if (pkt_error !== 1'b1) begin
         n_errors++;
         $display("FAIL rerror_timing: pkt_error=%b expected 1 on cycle after r_error", pkt_error);
      end
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
      repeat (3) tick();
      rcving = 1'b0;
      settle();
      ok = (obs_data.size() == 3);
      for (int i = 0; ok && i < 3; i++) ok = (obs_data[i] === d[i]);
      n_checks++;
      if (!ok || obs_err !== 1 || obs_done !== 0 || byte_cnt !== 7'd3) begin
         n_errors++;
         $display("FAIL rerror_data: strobes=%0d err=%0d done=%0d byte_cnt=%0d expected 3 1 0 3",
                  obs_data.size(), obs_err, obs_done, byte_cnt);
      end
   endtask

   task automatic test_reset_mid_token();
      logic [7:0] pk[$];
      logic [7:0] a, e;
      clear_obs();
      rcving = 1'b1;
      q.push_back(8'h69);
      repeat (3) tick();
      q.push_back(8'h85);
      update_fifo();
      #1;
      n_rst = 1'b0;
      #1;
      n_checks++;
      if ({r_enable, pid, addr, endp, data_out, data_valid, byte_cnt, pkt_done, pkt_error} !== 35'd0) begin
         n_errors++;
         $display("FAIL reset_mid_token: got %h expected 0",
                  {r_enable, pid, addr, endp, data_out, data_valid, byte_cnt, pkt_done, pkt_error});
      end
      q.delete();
      rcving = 1'b0;
      update_fifo();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      a = 8'($urandom);
      e = 8'($urandom);
      pk = '{8'hE1, a, e};
      send_pkt(pk);
      n_checks++;
      if (pid !== 4'h1 || addr !== a[6:0] || endp !== {e[2:0], a[7]} ||
          obs_done !== 1 || obs_err !== 0) begin
         n_errors++;
         $display("FAIL out_after_reset: pid=%h addr=%h endp=%h done=%0d err=%0d expected 1 %h %h 1 0",
                  pid, addr, endp, obs_done, obs_err, a[6:0], {e[2:0], a[7]});
      end
   endtask

   initial begin
      test_reset();
      test_random();
      test_in_token();
      test_data0();
      test_bad_pid();
      test_ack_extra();
      test_rerror_mid_data();
      test_reset_mid_token();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
